// File: rtl/sw_debounce_pkg.sv
// Shared constants for the three-channel switch debouncer.
package sw_debounce_pkg;

    localparam int unsigned SW_CH               = 3;
    // 1 ms at a 50 MHz board clock
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/sw_debounce3_if.sv
// Raw switch levels in, debounced levels out; edge pulses only with SW_DEBOUNCE_EDGE_EN.
interface sw_debounce3_if
    import sw_debounce_pkg::*;
();

    logic a;
    logic b;
    logic c;
    logic a_db;
    logic b_db;
    logic c_db;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [SW_CH-1:0] rise;
    logic [SW_CH-1:0] fall;

    modport master (output a, b, c, input a_db, b_db, c_db, rise, fall);
    modport slave  (input a, b, c, output a_db, b_db, c_db, rise, fall);
`else
    modport master (output a, b, c, input a_db, b_db, c_db);
    modport slave  (input a, b, c, output a_db, b_db, c_db);
`endif

endinterface

// File: rtl/sw_debounce3_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, stable level q.
// Optional registered rise/fall pulses under SW_DEBOUNCE_EDGE_EN.
module debounce_ch
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic db_o
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             commit_c;

    // Any return of s2 to the stable level aborts the pending count
    always_comb begin
        cnt_d    = '0;
        lvl_d    = lvl_q;
        commit_c = 1'b0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d    = s2_q;
                commit_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end

    assign db_o = lvl_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Pulses land on the same edge that q takes its new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= commit_c &  s2_q;
            fall_q <= commit_c & ~s2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    logic unused_commit_c;
    assign unused_commit_c = commit_c;
`endif

endmodule

// File: rtl/sw_debounce3.sv
// Three-channel switch conditioner feeding the board OR stage.
// Define SW_DEBOUNCE_EDGE_EN to add the rise/fall pulse outputs.
module sw_debounce3
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    sw_debounce3_if.slave  sw
);

    logic [SW_CH-1:0] raw;
    logic [SW_CH-1:0] db;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [SW_CH-1:0] rise;
    logic [SW_CH-1:0] fall;
`endif

    assign raw = {sw.c, sw.b, sw.a};

    for (genvar i = 0; i < SW_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw[i]),
            .db_o   (db[i])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .rise_o (rise[i]),
            .fall_o (fall[i])
`endif
        );
    end

    assign sw.a_db = db[0];
    assign sw.b_db = db[1];
    assign sw.c_db = db[2];
`ifdef SW_DEBOUNCE_EDGE_EN
    assign sw.rise = rise;
    assign sw.fall = fall;
`endif

endmodule

// File: tb/tb_sw_debounce3.sv
// Directed bench for sw_debounce3 at DEBOUNCE_CYCLES = 4; edge checks only with SW_DEBOUNCE_EDGE_EN.
module tb_sw_debounce3;
    import sw_debounce_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] dbv;
    int         passed;
    int         total;

    sw_debounce3_if sw_if ();

    sw_debounce3 #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    assign dbv = {sw_if.c_db, sw_if.b_db, sw_if.a_db};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_edge(input string tag, input logic [2:0] exp_rise, input logic [2:0] exp_fall);
`ifdef SW_DEBOUNCE_EDGE_EN
        check({tag, "_rise"}, sw_if.rise, exp_rise);
        check({tag, "_fall"}, sw_if.fall, exp_fall);
`else
        if (exp_rise !== exp_fall) begin end
`endif
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        sw_if.a = 1'b1;
        sw_if.b = 1'b1;
        sw_if.c = 1'b1;

        // reset held with inputs high
        repeat (3) tick();
        check("reset_db", dbv, 3'b000);
        chk_edge("reset", 3'b000, 3'b000);
        sw_if.a = 1'b0;
        sw_if.b = 1'b0;
        sw_if.c = 1'b0;
        tick();
        check("reset_db2", dbv, 3'b000);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_db", dbv, 3'b000);

        // clean press on a: visible after edge 6
        sw_if.a = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("press_db_e%0d", k), dbv, (k >= 6) ? 3'b001 : 3'b000);
            chk_edge($sformatf("press_e%0d", k), (k == 6) ? 3'b001 : 3'b000, 3'b000);
        end

        // bounce on b, 2-cycle pulses, then hold low
        for (int i = 0; i < 4; i++) begin
            sw_if.b = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick();
                check($sformatf("bounce_db_%0d_%0d", i, j), dbv, 3'b001);
                chk_edge("bounce", 3'b000, 3'b000);
            end
        end
        sw_if.b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("bounce_hold_e%0d", k), dbv, 3'b001);
            chk_edge("bounce_hold", 3'b000, 3'b000);
        end

        // bring c high
        sw_if.c = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("c_up_db_e%0d", k), dbv, (k >= 6) ? 3'b101 : 3'b001);
            chk_edge($sformatf("c_up_e%0d", k), (k == 6) ? 3'b100 : 3'b000, 3'b000);
        end

        // release c with bounce 0,1 then hold 0
        sw_if.c = 1'b0;
        tick();
        check("rel_bounce0", dbv, 3'b101);
        sw_if.c = 1'b1;
        tick();
        check("rel_bounce1", dbv, 3'b101);
        sw_if.c = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("rel_db_e%0d", k), dbv, (k >= 6) ? 3'b001 : 3'b101);
            chk_edge($sformatf("rel_e%0d", k), 3'b000, (k == 6) ? 3'b100 : 3'b000);
        end

        // drop a so all channels are low
        sw_if.a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("a_dn_db_e%0d", k), dbv, (k >= 6) ? 3'b000 : 3'b001);
            chk_edge($sformatf("a_dn_e%0d", k), 3'b000, (k == 6) ? 3'b001 : 3'b000);
        end

        // simultaneous press on all channels
        sw_if.a = 1'b1;
        sw_if.b = 1'b1;
        sw_if.c = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("simul_db_e%0d", k), dbv, (k >= 6) ? 3'b111 : 3'b000);
            chk_edge($sformatf("simul_e%0d", k), (k == 6) ? 3'b111 : 3'b000, 3'b000);
        end

        // settle all low again
        sw_if.a = 1'b0;
        sw_if.b = 1'b0;
        sw_if.c = 1'b0;
        repeat (8) tick();
        check("settle_db", dbv, 3'b000);

        // reset while a's counter sits at 2
        sw_if.a = 1'b1;
        repeat (4) tick();
        check("mid_pre_db", dbv, 3'b000);
        rst = 1'b1;
        #1;
        check("mid_rst_db", dbv, 3'b000);
        chk_edge("mid_rst", 3'b000, 3'b000);
        tick();
        tick();
        check("mid_rst_hold_db", dbv, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("requal_db_e%0d", k), dbv, (k >= 6) ? 3'b001 : 3'b000);
            chk_edge($sformatf("requal_e%0d", k), (k == 6) ? 3'b001 : 3'b000, 3'b000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
